// File: rtl/sparc_muldiv_seq.sv
// rtl/sparc_muldiv_seq.sv - multi-cycle SPARC UMUL/SMUL/UDIV/SDIV sequencer
//
// Purpose: runs one integer multiply (radix-2 shift-add) or divide (restoring,
// on magnitudes) over 32 iteration cycles plus a sign-fixup cycle, stalls the
// pipeline through busy, and owns the Y register (upper half of every product).
//
// Ports:
//   MDS_clk_in       clock, rising edge
//   MDS_rst_in       asynchronous active-high reset
//   MDS_start_in     issue strobe
//   MDS_op3_in       SPARC op3: 0A UMUL, 0B SMUL, 0E UDIV, 0F SDIV
//   MDS_valA_in      rs1 operand
//   MDS_valB_in      second operand (register or sign-extended simm13)
//   MDS_rd_in        destination register tag
//   MDS_flush_in     abort the in-flight operation
//   MDS_busy_out     pipeline stall request
//   MDS_done_out     one-cycle result-valid pulse
//   MDS_res_out      low product or quotient
//   MDS_rd_out       destination tag returned with the result
//   MDS_divzero_out  divide by zero, meaningful while done is high
//   MDS_y_out        current Y register
module sparc_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             MDS_clk_in,
  input  logic             MDS_rst_in,
  input  logic             MDS_start_in,
  input  logic [5:0]       MDS_op3_in,
  input  logic [WIDTH-1:0] MDS_valA_in,
  input  logic [WIDTH-1:0] MDS_valB_in,
  input  logic [4:0]       MDS_rd_in,
  input  logic             MDS_flush_in,
  output logic             MDS_busy_out,
  output logic             MDS_done_out,
  output logic [WIDTH-1:0] MDS_res_out,
  output logic [4:0]       MDS_rd_out,
  output logic             MDS_divzero_out,
  output logic [WIDTH-1:0] MDS_y_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2*WIDTH-1:0] r_acc;       // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_opb;       // multiplicand or divisor magnitude
  logic [4:0]         r_cnt;
  logic               r_neg;
  logic               r_is_mul;
  logic               r_is_signed;
  logic [4:0]         r_rd_pend;
  logic [WIDTH-1:0]   r_res;
  logic [4:0]         r_rd_out;
  logic               r_divzero;
  logic [WIDTH-1:0]   r_y;

  logic               w_legal;
  logic               w_op_mul;
  logic               w_op_signed;
  logic               w_accept;
  logic               w_divzero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_trial;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_fix_res;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  // op3 decode: bit 2 separates divide from multiply, bit 0 marks signed.
  assign w_legal     = (MDS_op3_in == 6'h0A) || (MDS_op3_in == 6'h0B) ||
                       (MDS_op3_in == 6'h0E) || (MDS_op3_in == 6'h0F);
  assign w_op_mul    = ~MDS_op3_in[2];
  assign w_op_signed = MDS_op3_in[0];
  assign w_accept    = MDS_start_in && w_legal &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_divzero   = ~w_op_mul && (MDS_valB_in == '0);

  assign w_mag_a = (w_op_signed && MDS_valA_in[WIDTH-1]) ? -MDS_valA_in : MDS_valA_in;
  assign w_mag_b = (w_op_signed && MDS_valB_in[WIDTH-1]) ? -MDS_valB_in : MDS_valB_in;

  // Shift-add: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right, carry in.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: remainder shifted left with the next dividend bit; the
  // true difference always fits in WIDTH bits when it is non-negative.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_trial = w_div_shift[WIDTH-1:0] - r_opb;
  assign w_div_step  = w_div_ge ? {w_div_trial, r_acc[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_acc[WIDTH-1:0];

  always_comb begin
    w_fix_res = w_quo;
    if (r_is_mul) begin
      w_fix_res = w_prod[WIDTH-1:0];
    end else if (r_is_signed) begin
      if (r_neg) begin
        w_fix_res = -w_quo;
      end else if (w_quo == MIN_NEG) begin
        w_fix_res = MAX_POS;  // only 0x80000000 / -1 reaches a positive 2^31
      end
    end
  end

  always_ff @(posedge MDS_clk_in or posedge MDS_rst_in) begin
    if (MDS_rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (w_accept) begin
          if (w_op_mul) begin
            w_next = S_MUL;
          end else if (w_divzero) begin
            w_next = S_DONE;
          end else begin
            w_next = S_DIV;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        w_busy = 1'b1;
        if (MDS_flush_in) begin
          w_next = S_IDLE;
        end else if (r_cnt == 5'd0) begin
          w_next = S_FIXUP;
        end
      end
      S_FIXUP: begin
        w_busy = 1'b1;
        w_next = MDS_flush_in ? S_IDLE : S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge MDS_clk_in or posedge MDS_rst_in) begin
    if (MDS_rst_in) begin
      r_acc       <= '0;
      r_opb       <= '0;
      r_cnt       <= 5'd0;
      r_neg       <= 1'b0;
      r_is_mul    <= 1'b0;
      r_is_signed <= 1'b0;
      r_rd_pend   <= 5'd0;
      r_res       <= '0;
      r_rd_out    <= 5'd0;
      r_divzero   <= 1'b0;
      r_y         <= '0;
    end else if (w_accept) begin
      r_acc       <= {{WIDTH{1'b0}}, w_mag_a};
      r_opb       <= w_mag_b;
      r_cnt       <= 5'd31;
      r_neg       <= w_op_signed && (MDS_valA_in[WIDTH-1] ^ MDS_valB_in[WIDTH-1]);
      r_is_mul    <= w_op_mul;
      r_is_signed <= w_op_signed;
      r_rd_pend   <= MDS_rd_in;
      if (w_divzero) begin
        // Zero divisor skips straight to DONE, so the result is posted now.
        r_res     <= '0;
        r_rd_out  <= MDS_rd_in;
        r_divzero <= 1'b1;
      end
    end else if (!MDS_flush_in) begin
      if (r_state == S_MUL) begin
        r_acc <= w_mul_step;
        r_cnt <= r_cnt - 5'd1;
      end else if (r_state == S_DIV) begin
        r_acc <= w_div_step;
        r_cnt <= r_cnt - 5'd1;
      end else if (r_state == S_FIXUP) begin
        r_res     <= w_fix_res;
        r_rd_out  <= r_rd_pend;
        r_divzero <= 1'b0;
        if (r_is_mul) begin
          r_y <= w_prod[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign MDS_busy_out    = w_busy;
  assign MDS_done_out    = w_done;
  assign MDS_res_out     = r_res;
  assign MDS_rd_out      = r_rd_out;
  assign MDS_divzero_out = r_divzero;
  assign MDS_y_out       = r_y;

endmodule

// File: tb/tb_sparc_muldiv_seq.sv
// tb/tb_sparc_muldiv_seq.sv - self-checking bench for sparc_muldiv_seq
module tb_sparc_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  op3;
  logic [31:0] val_a;
  logic [31:0] val_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic [4:0]  rd_out;
  logic        divzero;
  logic [31:0] y;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] g_y;
  logic [31:0] g_res;
  logic [4:0]  g_rd;

  sparc_muldiv_seq #(.WIDTH(32)) dut (
    .MDS_clk_in      (clk),
    .MDS_rst_in      (rst),
    .MDS_start_in    (start),
    .MDS_op3_in      (op3),
    .MDS_valA_in     (val_a),
    .MDS_valB_in     (val_b),
    .MDS_rd_in       (rd_in),
    .MDS_flush_in    (flush),
    .MDS_busy_out    (busy),
    .MDS_done_out    (done),
    .MDS_res_out     (res),
    .MDS_rd_out      (rd_out),
    .MDS_divzero_out (divzero),
    .MDS_y_out       (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [31:0] exp_y;
    logic        exp_dz;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural operation.
  task automatic ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] y_in, output logic [31:0] r,
                           output logic [31:0] y_o, output logic dz);
    logic [63:0]        p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    y_o = y_in;
    dz  = 1'b0;
    r   = 32'd0;
    case (op)
      6'h0A: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; y_o = p[63:32]; end
      6'h0B: begin p = sa * sb; r = p[31:0]; y_o = p[63:32]; end
      6'h0E: begin if (b == 32'd0) dz = 1'b1; else r = a / b; end
      default: begin
        if (b == 32'd0) dz = 1'b1;
        else begin
          q = sa / sb;
          r = (q > 64'sd2147483647) ? 32'h7FFFFFFF : q[31:0];
        end
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge of the done cycle so a
  // following call issues back-to-back.
  task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] er, input logic [31:0] ey, input logic edz);
    int lat;
    int bc;
    int elat;
    lat  = -1;
    bc   = 0;
    elat = edz ? 1 : 34;
    start = 1'b1; op3 = op; val_a = a; val_b = b; rd_in = rd;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
        break;
      end
      if (busy) bc++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(elat - 1));
    chk({nm, "_res"}, 64'(res), 64'(er));
    chk({nm, "_rd"}, 64'(rd_out), 64'(rd));
    chk({nm, "_divzero"}, 64'(divzero), 64'(edz));
    chk({nm, "_y"}, 64'(y), 64'(ey));
    g_y = ey; g_res = er; g_rd = rd;
  endtask

  vec_t tbl[13];

  initial begin
    logic [31:0] er;
    logic [31:0] ey;
    logic        edz;
    logic [5:0]  ops[4];
    int          cnt;

    ops[0] = 6'h0A; ops[1] = 6'h0B; ops[2] = 6'h0E; ops[3] = 6'h0F;
    tbl[0]  = '{6'h0A, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[1]  = '{6'h0B, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{6'h0A, 32'h00000003, 32'h00000003, 32'h00000009, 32'h00000000, 1'b0};
    tbl[3]  = '{6'h0A, 32'h00010000, 32'h00030000, 32'h00000000, 32'h00000003, 1'b0};
    tbl[4]  = '{6'h0E, 32'd100,      32'd7,        32'd14,       32'h00000003, 1'b0};
    tbl[5]  = '{6'h0F, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'h00000003, 1'b0};
    tbl[6]  = '{6'h0F, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000003, 1'b0};
    tbl[7]  = '{6'h0E, 32'd5,        32'd0,        32'd0,        32'h00000003, 1'b1};
    tbl[8]  = '{6'h0F, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000003, 1'b0};
    tbl[9]  = '{6'h0F, 32'h80000000, 32'd1,        32'h80000000, 32'h00000003, 1'b0};
    tbl[10] = '{6'h0E, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000003, 1'b0};
    tbl[11] = '{6'h0B, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
    tbl[12] = '{6'h0B, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};

    rst = 1'b1; start = 1'b0; op3 = 6'h00; val_a = 32'd0; val_b = 32'd0;
    rd_in = 5'd0; flush = 1'b0;
    g_y = 32'd0; g_res = 32'd0; g_rd = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_res", 64'(res), 64'd0);
    chk("reset_y", 64'(y), 64'd0);
    chk("reset_rd", 64'(rd_out), 64'd0);
    chk("reset_divzero", 64'(divzero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table, issued back-to-back in each DONE cycle.
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1),
             tbl[i].exp_res, tbl[i].exp_y, tbl[i].exp_dz);
    end
    @(negedge clk);
    chk("done_single_cycle", 64'(done), 64'd0);
    chk("hold_res", 64'(res), 64'(g_res));
    chk("hold_rd", 64'(rd_out), 64'(g_rd));

    // Flush sampled at edge 10 of a UMUL.
    start = 1'b1; op3 = 6'h0A; val_a = 32'h12345678; val_b = 32'h9ABCDEF0; rd_in = 5'd30;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("flush_no_done", 64'(cnt), 64'd0);
    chk("flush_y_hold", 64'(y), 64'(g_y));
    chk("flush_res_hold", 64'(res), 64'(g_res));
    chk("flush_rd_hold", 64'(rd_out), 64'(g_rd));

    // Illegal op3 is ignored.
    start = 1'b1; op3 = 6'h00; val_a = 32'd4; val_b = 32'd4; rd_in = 5'd9;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("illegal_ignored", 64'(cnt), 64'd0);
    chk("illegal_res_hold", 64'(res), 64'(g_res));

    // Randomized ops against the reference model, with optional idle gaps.
    for (int k = 0; k < 40; k++) begin
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = ops[$urandom_range(0, 3)];
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      ref_model(op, a, b, g_y, er, ey, edz);
      run_op($sformatf("rnd%0d", k), op, a, b, 5'($urandom_range(0, 31)), er, ey, edz);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk($sformatf("rnd%0d_gap_done", k), 64'(done), 64'd0);
      end
    end

    // Asynchronous reset in the middle of a divide.
    run_op("pre_rst", 6'h0A, 32'h12345678, 32'h00000100, 5'd17,
           32'h34567800, 32'h00000012, 1'b0);
    start = 1'b1; op3 = 6'h0E; val_a = 32'd1000; val_b = 32'd3; rd_in = 5'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_res", 64'(res), 64'd0);
    chk("arst_rd", 64'(rd_out), 64'd0);
    chk("arst_divzero", 64'(divzero), 64'd0);
    chk("arst_y", 64'(y), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post_rst", 6'h0E, 32'd9, 32'd3, 5'd5, 32'd3, 32'd0, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
